inter_buffer_ctrl: RTL and testbench

//  Sequencer for INTERMEDIATE_BUFFER between ALU layers of the NN accelerator.

---
 rtl/inter_buffer_ctrl.sv | 154 +++++++++++++++
 tb/tb_inter_buffer_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inter_buffer_ctrl.sv
// Sequencer for the intermediate buffer between ALU layers: waits for a layer's
// outputs, captures them, streams NUM_NEURONS words downstream, then launches the next layer.
module inter_buffer_ctrl #(
    parameter int NUM_NEURONS = 2,
    parameter int NUM_LAYERS  = 3,
    localparam int CNT_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int LAY_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             layer_done,
    input  logic             next_ready,
    output logic             cap_en,
    output logic             shift_en,
    output logic             word_valid,
    output logic             word_last,
    output logic [CNT_W-1:0] word_idx,
    output logic [LAY_W-1:0] layer_idx,
    output logic             alu_start,
    output logic             net_done,
    output logic             busy,
    output logic             err_overrun
);

    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(NUM_NEURONS - 1);
    localparam logic [LAY_W-1:0] LAST_LAYER = LAY_W'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_LAYER,
        CAPTURE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [LAY_W-1:0] layer_idx_q, layer_idx_d;
    logic             err_overrun_q, err_overrun_d;
    logic             alu_start_q, alu_start_d;
    logic             cap_en_q, cap_en_d;
    logic             word_valid_q, word_valid_d;
    logic             word_last_q, word_last_d;
    logic             net_done_q, net_done_d;
    logic             busy_q, busy_d;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        layer_idx_d   = layer_idx_q;
        err_overrun_d = err_overrun_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = LAUNCH;
                    layer_idx_d   = '0;
                    err_overrun_d = 1'b0;
                end
            end
            LAUNCH: begin
                state_d = WAIT_LAYER;
            end
            WAIT_LAYER: begin
                if (layer_done) begin
                    state_d    = CAPTURE;
                    word_idx_d = '0;
                end
            end
            CAPTURE: begin
                state_d    = SHIFT;
                word_idx_d = '0;
            end
            SHIFT: begin
                if (next_ready) begin
                    if (word_idx_q == LAST_WORD) begin
                        if (layer_idx_q == LAST_LAYER) begin
                            state_d = DONE;
                        end else begin
                            layer_idx_d = layer_idx_q + LAY_W'(1);
                            state_d     = LAUNCH;
                        end
                    end else begin
                        word_idx_d = word_idx_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                layer_idx_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stray layer_done is flagged after the start-clear above, so the set wins.
        if (layer_done && (state_q != WAIT_LAYER)) begin
            err_overrun_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they appear as clean flops in the state's cycle.
    always_comb begin
        alu_start_d  = (state_d == LAUNCH);
        cap_en_d     = (state_d == CAPTURE);
        word_valid_d = (state_d == SHIFT);
        word_last_d  = (state_d == SHIFT) && (word_idx_d == LAST_WORD);
        net_done_d   = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            word_idx_q    <= '0;
            layer_idx_q   <= '0;
            err_overrun_q <= 1'b0;
            alu_start_q   <= 1'b0;
            cap_en_q      <= 1'b0;
            word_valid_q  <= 1'b0;
            word_last_q   <= 1'b0;
            net_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            layer_idx_q   <= layer_idx_d;
            err_overrun_q <= err_overrun_d;
            alu_start_q   <= alu_start_d;
            cap_en_q      <= cap_en_d;
            word_valid_q  <= word_valid_d;
            word_last_q   <= word_last_d;
            net_done_q    <= net_done_d;
            busy_q        <= busy_d;
        end
    end

    assign shift_en    = word_valid_q & next_ready;
    assign cap_en      = cap_en_q;
    assign word_valid  = word_valid_q;
    assign word_last   = word_last_q;
    assign word_idx    = word_idx_q;
    assign layer_idx   = layer_idx_q;
    assign alu_start   = alu_start_q;
    assign net_done    = net_done_q;
    assign busy        = busy_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_inter_buffer_ctrl.sv
// Self-checking bench for inter_buffer_ctrl: a 2-neuron/3-layer instance under random
// handshakes and overruns, plus a 1-neuron/1-layer instance for the degenerate case.
module tb_inter_buffer_ctrl;

    localparam int NN = 2;
    localparam int NL = 3;
    localparam int CW = 1;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start, layer_done, next_ready;
    logic          cap_en, shift_en, word_valid, word_last, alu_start, net_done, busy, err_overrun;
    logic [CW-1:0] word_idx;
    logic [LW-1:0] layer_idx;

    logic          start_s, layer_done_s, next_ready_s;
    logic          cap_en_s, shift_en_s, word_valid_s, word_last_s, alu_start_s, net_done_s;
    logic          busy_s, err_overrun_s;
    logic [0:0]    word_idx_s, layer_idx_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inter_buffer_ctrl #(.NUM_NEURONS(NN), .NUM_LAYERS(NL)) dut (
        .clk(clk), .rst(rst), .start(start), .layer_done(layer_done), .next_ready(next_ready),
        .cap_en(cap_en), .shift_en(shift_en), .word_valid(word_valid), .word_last(word_last),
        .word_idx(word_idx), .layer_idx(layer_idx), .alu_start(alu_start), .net_done(net_done),
        .busy(busy), .err_overrun(err_overrun)
    );

    inter_buffer_ctrl #(.NUM_NEURONS(1), .NUM_LAYERS(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .layer_done(layer_done_s), .next_ready(next_ready_s),
        .cap_en(cap_en_s), .shift_en(shift_en_s), .word_valid(word_valid_s), .word_last(word_last_s),
        .word_idx(word_idx_s), .layer_idx(layer_idx_s), .alu_start(alu_start_s), .net_done(net_done_s),
        .busy(busy_s), .err_overrun(err_overrun_s)
    );

    // One full network evaluation on the 2x3 instance. Cycle 0 is the start cycle; the
    // reference is the sequence of events the rules predict: alu_start for layer L right after
    // the previous layer's last handshake, cap_en one cycle after the accepted layer_done, the
    // first word the cycle after cap_en, handshake j carrying word j%NN of layer j/NN.
    task automatic run_net(input int ready_pct, input int min_dly, input int max_dly,
                           input bit inject, input bit spam, input bit start_with_done,
                           input bit hold4,
                           output int n_alu, output int n_cap, output int n_words, output int n_done);
        int pend_done = -1;
        int last_ld   = -1;
        int last_hs   = -1;
        int cap_cyc   = -1;
        int done_cyc  = -1;
        int inj_cyc   = -1;
        int stall_left = hold4 ? 4 : 0;
        int stall_idx  = -1;
        bit finished  = 1'b0;
        bit exp_err;
        bit exp_last;
        n_alu = 0; n_cap = 0; n_words = 0; n_done = 0;
        @(negedge clk);
        start = 1'b1; layer_done = start_with_done; next_ready = 1'b0;
        for (int t = 1; t <= 400 && !finished; t++) begin
            @(negedge clk);
            start = 1'b0; layer_done = 1'b0;
            exp_err = start_with_done || (inj_cyc >= 0);
            checks++;
            if (err_overrun !== exp_err)
                begin errors++; $display("FAIL err_overrun cycle %0d: got %b want %b", t, err_overrun, exp_err); end
            if (done_cyc >= 0) begin
                checks++;
                if (busy !== 1'b0 || alu_start !== 1'b0 || word_valid !== 1'b0)
                    begin errors++; $display("FAIL idle_after_done: busy %b alu_start %b word_valid %b want 0 0 0", busy, alu_start, word_valid); end
                finished = 1'b1;
            end else begin
                checks++;
                if (busy !== 1'b1)
                    begin errors++; $display("FAIL busy cycle %0d: got %b want 1", t, busy); end
                if (alu_start === 1'b1) begin
                    checks++;
                    if (t != ((n_alu == 0) ? 1 : last_hs + 1) || layer_idx !== LW'(n_alu))
                        begin errors++; $display("FAIL alu_start #%0d: cycle %0d layer %0d, want cycle %0d layer %0d",
                                                 n_alu, t, layer_idx, (n_alu == 0) ? 1 : last_hs + 1, n_alu); end
                    n_alu++;
                    pend_done = t + $urandom_range(max_dly, min_dly);
                end
                if (cap_en === 1'b1) begin
                    checks++;
                    if (t != last_ld + 1 || layer_idx !== LW'(n_cap))
                        begin errors++; $display("FAIL cap_en #%0d: cycle %0d layer %0d, want cycle %0d layer %0d",
                                                 n_cap, t, layer_idx, last_ld + 1, n_cap); end
                    n_cap++;
                    cap_cyc = t;
                end
                if (cap_cyc >= 0 && t == cap_cyc + 1) begin
                    checks++;
                    if (word_valid !== 1'b1 || word_idx !== CW'(0))
                        begin errors++; $display("FAIL first_word cycle %0d: valid %b idx %0d want 1 0", t, word_valid, word_idx); end
                end
                if (net_done === 1'b1) begin
                    checks++;
                    if (t != last_hs + 1 || n_words != NN * NL)
                        begin errors++; $display("FAIL net_done: cycle %0d after %0d words, want cycle %0d after %0d",
                                                 t, n_words, last_hs + 1, NN * NL); end
                    n_done++;
                    done_cyc = t;
                end
                next_ready = ($urandom_range(99, 0) < ready_pct);
                if (word_valid === 1'b1 && stall_left > 0) begin
                    next_ready = 1'b0;
                    if (stall_idx < 0) stall_idx = int'(word_idx);
                    checks++;
                    if (int'(word_idx) != stall_idx)
                        begin errors++; $display("FAIL stall_hold: word_idx %0d want %0d", word_idx, stall_idx); end
                    stall_left--;
                end
                if (t == pend_done) begin
                    layer_done = 1'b1;
                    last_ld = t;
                end
                if (inject && inj_cyc < 0 && word_valid === 1'b1 && n_words >= 1) begin
                    layer_done = 1'b1;
                    inj_cyc = t;
                end
                if (spam && $urandom_range(2, 0) == 0) start = 1'b1;
                #1;
                checks++;
                if (shift_en !== (word_valid & next_ready))
                    begin errors++; $display("FAIL shift_en cycle %0d: got %b want %b", t, shift_en, word_valid & next_ready); end
                if (word_valid === 1'b1 && next_ready) begin
                    exp_last = ((n_words % NN) == NN - 1);
                    checks++;
                    if (word_idx !== CW'(n_words % NN) || layer_idx !== LW'(n_words / NN) || word_last !== exp_last)
                        begin errors++; $display("FAIL word #%0d: idx %0d layer %0d last %b, want %0d %0d %b",
                                                 n_words, word_idx, layer_idx, word_last, n_words % NN, n_words / NN, exp_last); end
                    n_words++;
                    last_hs = t;
                end
            end
        end
        if (!finished) begin
            errors++;
            $display("FAIL run_timeout: no net_done within 400 cycles (words %0d, want %0d)", n_words, NN * NL);
        end
        start = 1'b0; layer_done = 1'b0; next_ready = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int a, input int c, input int w, input int d);
        checks++;
        if (a != NL || c != NL || w != NN * NL || d != 1)
            begin errors++; $display("FAIL %s counts: alu %0d cap %0d words %0d done %0d, want %0d %0d %0d 1",
                                     tag, a, c, w, d, NL, NL, NN * NL); end
    endtask

    task automatic test_reset();
        int a, c, w, d;
        bit seen = 1'b0;
        #3;
        checks++;
        if ({cap_en, shift_en, word_valid, word_last, alu_start, net_done, busy, err_overrun} !== 8'h00 ||
            word_idx !== '0 || layer_idx !== '0 || busy_s !== 1'b0 || word_last_s !== 1'b0)
            begin errors++; $display("FAIL reset_state: outputs not all zero (busy %b word_last_s %b)", busy, word_last_s); end
        @(negedge clk);
        rst = 1'b0;
        // Bring the 2x3 instance into SHIFT, then reset asynchronously mid-cycle.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (word_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reach_shift: word_valid %b want 1", word_valid); end
        next_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cap_en, shift_en, word_valid, word_last, alu_start, net_done, busy, err_overrun} !== 8'h00 ||
            word_idx !== '0 || layer_idx !== '0)
            begin errors++; $display("FAIL reset_mid_shift: valid %b shift_en %b busy %b want 0 0 0", word_valid, shift_en, busy); end
        next_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || alu_start !== 1'b0 || cap_en !== 1'b0 || word_valid !== 1'b0 || net_done !== 1'b0)
                begin errors++; $display("FAIL post_reset_idle: busy %b alu %b cap %b valid %b done %b want all 0",
                                         busy, alu_start, cap_en, word_valid, net_done); end
        end
        run_net(100, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, a, c, w, d);
        check_counts("after_reset", a, c, w, d);
    endtask

    task automatic test_basic();
        int a, c, w, d;
        run_net(100, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0, a, c, w, d);
        check_counts("basic", a, c, w, d);
    endtask

    task automatic test_backpressure();
        int a, c, w, d;
        run_net(100, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1, a, c, w, d);
        check_counts("stall4", a, c, w, d);
        for (int i = 0; i < 4; i++) begin
            run_net(20 + 20 * i, 1, 5, 1'b0, 1'b0, 1'b0, 1'b0, a, c, w, d);
            check_counts("random_ready", a, c, w, d);
        end
    endtask

    task automatic test_overrun();
        int a, c, w, d;
        run_net(60, 1, 4, 1'b1, 1'b0, 1'b0, 1'b0, a, c, w, d);
        check_counts("overrun", a, c, w, d);
        checks++;
        if (err_overrun !== 1'b1)
            begin errors++; $display("FAIL err_sticky_idle: got %b want 1", err_overrun); end
        run_net(100, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, a, c, w, d);
        check_counts("clear_run", a, c, w, d);
        run_net(100, 1, 3, 1'b0, 1'b0, 1'b1, 1'b0, a, c, w, d);
        check_counts("start_with_done", a, c, w, d);
        run_net(80, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, a, c, w, d);
        check_counts("clear_again", a, c, w, d);
    endtask

    task automatic test_start_while_busy();
        int a, c, w, d;
        for (int i = 0; i < 3; i++) begin
            run_net(70, 1, 4, 1'b0, 1'b1, 1'b0, 1'b0, a, c, w, d);
            check_counts("start_busy", a, c, w, d);
        end
    endtask

    task automatic test_single();
        int ld = -1, k_alu = -1, k_cap = -1, k_word = -1, k_done = -1, n_w = 0;
        @(negedge clk);
        start_s = 1'b1;
        for (int t = 1; t <= 40 && k_done < 0; t++) begin
            @(negedge clk);
            start_s = 1'b0; layer_done_s = 1'b0; next_ready_s = 1'b1;
            if (alu_start_s === 1'b1) begin
                k_alu = t;
                ld = t + $urandom_range(4, 1);
            end
            if (t == ld) layer_done_s = 1'b1;
            #1;
            if (cap_en_s === 1'b1) begin
                k_cap = t;
                checks++;
                if (word_last_s !== 1'b0)
                    begin errors++; $display("FAIL single_last_at_cap: got %b want 0", word_last_s); end
            end
            if (word_valid_s === 1'b1) begin
                n_w++;
                k_word = t;
                checks++;
                if (word_last_s !== 1'b1 || word_idx_s !== 1'b0 || layer_idx_s !== 1'b0 || shift_en_s !== 1'b1)
                    begin errors++; $display("FAIL single_word: last %b idx %0d layer %0d shift_en %b want 1 0 0 1",
                                             word_last_s, word_idx_s, layer_idx_s, shift_en_s); end
            end
            if (net_done_s === 1'b1) k_done = t;
        end
        next_ready_s = 1'b0;
        checks++;
        if (k_alu != 1 || k_cap != ld + 1 || k_word != ld + 2 || n_w != 1 || k_done != ld + 3)
            begin errors++; $display("FAIL single_timing: alu %0d cap %0d word %0d words %0d done %0d, want 1 %0d %0d 1 %0d",
                                     k_alu, k_cap, k_word, n_w, k_done, ld + 1, ld + 2, ld + 3); end
        @(negedge clk);
        checks++;
        if (busy_s !== 1'b0)
            begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy_s); end
    endtask

    initial begin
        start = 1'b0; layer_done = 1'b0; next_ready = 1'b0;
        start_s = 1'b0; layer_done_s = 1'b0; next_ready_s = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_start_while_busy();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
